// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider iteration count and divider state encoding.
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITER + 1);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_sub.sv
// Combinational W-bit subtractor with borrow-out; shared by the divider and the ALU SUB/SLT paths.
module alu_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // Borrow is the top bit of the zero-extended difference: set when b > a.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle 32-bit restoring divider (signed/unsigned), one quotient bit per cycle.
module alu_div_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] inA,
  input  logic [XLEN-1:0] inB,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero
);

  div_state_t           state_q, state_d;
  logic [2*XLEN:0]      acc_q, acc_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic [XLEN-1:0]      orig_a_q, orig_a_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      quotient_q, quotient_d;
  logic [XLEN-1:0]      remainder_q, remainder_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic [2*XLEN:0]      acc_shift;
  logic [XLEN:0]        sub_a, sub_b, diff;
  logic                 borrow;
  logic [XLEN-1:0]      dvd_next;
  logic [XLEN-1:0]      a_mag, b_mag;
  logic                 accept;

  // acc holds {partial remainder (33b), dividend/quotient (32b)}.
  assign acc_shift = acc_q << 1;
  assign sub_a     = acc_shift[2*XLEN:XLEN];
  assign sub_b     = {1'b0, dvs_q};

  alu_sub #(
    .W(XLEN + 1)
  ) u_sub (
    .a     (sub_a),
    .b     (sub_b),
    .diff  (diff),
    .borrow(borrow)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    orig_a_d    = orig_a_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dz_d        = dz_q;

    // The vacated low bit of the shifted dividend receives the new quotient bit.
    dvd_next    = acc_shift[XLEN-1:0];
    dvd_next[0] = ~borrow;

    a_mag  = (is_signed && inA[XLEN-1]) ? -inA : inA;
    b_mag  = (is_signed && inB[XLEN-1]) ? -inB : inB;
    accept = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: ;
      CALC: begin
        if (dvs_q == '0) begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = orig_a_q;
          dz_d        = 1'b1;
          done_d      = 1'b1;
        end else if (cnt_q == DIV_LAST) begin
          state_d     = DONE;
          quotient_d  = q_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          remainder_d = r_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
          dz_d        = 1'b0;
          done_d      = 1'b1;
        end else begin
          acc_d = {(borrow ? sub_a : diff), dvd_next};
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // The DONE->IDLE edge also samples start, so back-to-back operations take 34 cycles.
    if (accept) begin
      state_d  = CALC;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      acc_d    = {{(XLEN + 1){1'b0}}, a_mag};
      dvs_d    = b_mag;
      orig_a_d = inA;
      q_neg_d  = is_signed & (inA[XLEN-1] ^ inB[XLEN-1]);
      r_neg_d  = is_signed & inA[XLEN-1];
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      dvs_q       <= '0;
      orig_a_q    <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      orig_a_q    <= orig_a_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed scoreboard bench for alu_div_unit: expected results queued at start, checked on done.
module tb_alu_div_unit;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, is_signed;
  logic [31:0] inA, inB;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  alu_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .inA        (inA),
    .inB        (inB),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint sa, sb;
    if (b == 32'd0) begin
      e.q   = 32'hFFFF_FFFF;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 1;
    end else begin
      e.dz  = 1'b0;
      e.lat = 33;
      if (s) begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        e.q = 32'(sa / sb);
        e.r = 32'(sa % sb);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    start     = 1'b1;
    inA       = a;
    inB       = b;
    is_signed = s;
    if (push) exp_q.push_back(model(a, b, s));
    $display("[TB] start %08h / %08h signed=%0d", a, b, s);
  endtask

  task automatic wait_done(input int inj, input bit hold);
    int   k;
    bit   busy_ok;
    exp_t e;
    k       = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (!hold) start = (k == inj);
      if (k == inj) begin
        inA       = 32'd1;
        inB       = 32'd1;
        is_signed = 1'b0;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (done !== 1'b1 && k < 100);
    check("done_seen", 32'(done), 32'd1);
    check("busy_during_op", 32'(busy_ok), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
      check("latency", 32'(k - 1), 32'(e.lat));
      $display("[TB] done q=%08h r=%08h dz=%0d latency=%0d", quotient, remainder, div_by_zero, k - 1);
    end
  endtask

  task automatic idle_gap();
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_released", 32'(busy), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_quotient"}, quotient, 32'd0);
    check({tag, "_remainder"}, remainder, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dz"}, 32'(div_by_zero), 32'd0);
  endtask

  initial begin
    bit saw_done;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    inA       = 32'd0;
    inB       = 32'd0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clk);

    drive(32'd100, 32'd7, 1'b0, 1'b1);         wait_done(0, 1'b0); idle_gap();
    drive(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);   wait_done(0, 1'b0); idle_gap();
    drive(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);   wait_done(0, 1'b0); idle_gap();
    drive(32'd5, 32'd0, 1'b0, 1'b1);           wait_done(0, 1'b0); idle_gap();
    drive(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);   wait_done(0, 1'b0); idle_gap();
    drive(32'd10, 32'd3, 1'b0, 1'b1);          wait_done(0, 1'b0); idle_gap();
    drive(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_done(0, 1'b0); idle_gap();
    drive(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);   wait_done(0, 1'b0); idle_gap();

    // A stray start 10 cycles into the operation must not disturb it.
    drive(32'd100, 32'd7, 1'b0, 1'b1);         wait_done(10, 1'b0); idle_gap();

    // start held through DONE: second op accepted on the DONE exit edge.
    drive(32'd10, 32'd3, 1'b0, 1'b1);          wait_done(0, 1'b1);
    exp_q.push_back(model(32'd10, 32'd3, 1'b0));
    wait_done(0, 1'b0);
    idle_gap();

    // Reset in cycle 15 of CALC discards the operation.
    drive(32'd100, 32'd7, 1'b0, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_cleared("midreset");
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    check("no_done_after_reset", 32'(saw_done), 32'd0);

    drive(32'd100, 32'd7, 1'b0, 1'b1);         wait_done(0, 1'b0); idle_gap();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
